// File: rtl/xgemac_pkt_loopback.sv
// rtl/xgemac_pkt_loopback.sv - store-and-forward packet loopback between xge_mac rx and tx client ports
// Optional statistics counters enabled by defining XGEMAC_LB_STATS_EN.
module xgemac_pkt_loopback #(
  parameter int DATA_W   = 64,
  parameter int MOD_W    = 3,
  parameter int DEPTH    = 256,
  parameter int DROP_ERR = 1
) (
  input  logic                     clk_156m25,
  input  logic                     reset_156m25_n,
  input  logic                     lb_en,
  input  logic                     pkt_rx_avail,
  output logic                     pkt_rx_ren,
  input  logic                     pkt_rx_val,
  input  logic                     pkt_rx_sop,
  input  logic                     pkt_rx_eop,
  input  logic [MOD_W-1:0]         pkt_rx_mod,
  input  logic                     pkt_rx_err,
  input  logic [DATA_W-1:0]        pkt_rx_data,
  input  logic                     pkt_tx_full,
  output logic                     pkt_tx_val,
  output logic                     pkt_tx_sop,
  output logic                     pkt_tx_eop,
  output logic [MOD_W-1:0]         pkt_tx_mod,
  output logic [DATA_W-1:0]        pkt_tx_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     drop_pulse
`ifdef XGEMAC_LB_STATS_EN
  ,
  output logic [31:0]              stat_rx_frames,
  output logic [31:0]              stat_tx_frames,
  output logic [31:0]              stat_drop_frames
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_W + MOD_W + 2;

  typedef enum logic [1:0] {RX_IDLE, RX_RUN, RX_DISCARD} rx_state_t;

  rx_state_t       state, state_nx;
  logic [PW-1:0]   wr, cm, rd, wr_nx, cm_nx;
  logic [WW-1:0]   mem [DEPTH];
  logic [WW-1:0]   rd_word;
  logic [PW-1:0]   used, base, base_inc, span;
  logic            mid, room_ok, we, drop_nx, rd_en;

  // A sop seen mid-frame restarts the frame at the commit point.
  assign used     = wr - rd;
  assign room_ok  = (used <= PW'(DEPTH - 2));
  assign mid      = (wr != cm);
  assign base     = (pkt_rx_sop && mid) ? cm : wr;
  assign base_inc = base + 1'b1;
  assign span     = base_inc - cm;

  always_comb begin
    state_nx   = state;
    wr_nx      = wr;
    cm_nx      = cm;
    drop_nx    = 1'b0;
    we         = 1'b0;
    pkt_rx_ren = 1'b0;
    case (state)
      RX_IDLE: begin
        if (lb_en && pkt_rx_avail) state_nx = RX_RUN;
      end
      RX_RUN: begin
        pkt_rx_ren = room_ok && !(pkt_rx_val && pkt_rx_eop);
        if (pkt_rx_val) begin
          we    = 1'b1;
          wr_nx = base_inc;
          if (pkt_rx_sop && mid) drop_nx = 1'b1;
          if (pkt_rx_eop) begin
            state_nx = RX_IDLE;
            if (pkt_rx_err && (DROP_ERR != 0)) begin
              wr_nx   = cm;
              drop_nx = 1'b1;
            end else begin
              cm_nx = base_inc;
            end
          end else if (span == PW'(DEPTH - 1)) begin
            wr_nx    = cm;
            drop_nx  = 1'b1;
            state_nx = RX_DISCARD;
          end
        end
      end
      RX_DISCARD: begin
        pkt_rx_ren = !(pkt_rx_val && pkt_rx_eop);
        if (pkt_rx_val && pkt_rx_eop) state_nx = RX_IDLE;
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      state      <= RX_IDLE;
      wr         <= '0;
      cm         <= '0;
      drop_pulse <= 1'b0;
    end else begin
      state      <= state_nx;
      wr         <= wr_nx;
      cm         <= cm_nx;
      drop_pulse <= drop_nx;
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (we) mem[base[AW-1:0]] <= {pkt_rx_data, pkt_rx_mod, pkt_rx_sop, pkt_rx_eop};
  end

  // Only committed words are read, so rd never aliases an address being written.
  assign rd_word    = mem[rd[AW-1:0]];
  assign rd_en      = (cm != rd) && !pkt_tx_full;
  assign fifo_level = cm - rd;

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      rd          <= '0;
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
      pkt_tx_data <= '0;
    end else if (rd_en) begin
      rd          <= rd + 1'b1;
      pkt_tx_val  <= 1'b1;
      pkt_tx_data <= rd_word[WW-1 -: DATA_W];
      pkt_tx_mod  <= rd_word[MOD_W+1:2];
      pkt_tx_sop  <= rd_word[1];
      pkt_tx_eop  <= rd_word[0];
    end else begin
      pkt_tx_val  <= 1'b0;
      pkt_tx_sop  <= 1'b0;
      pkt_tx_eop  <= 1'b0;
      pkt_tx_mod  <= '0;
    end
  end

`ifdef XGEMAC_LB_STATS_EN
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      stat_rx_frames   <= '0;
      stat_tx_frames   <= '0;
      stat_drop_frames <= '0;
    end else begin
      if ((state != RX_IDLE) && pkt_rx_val && pkt_rx_eop && (stat_rx_frames != '1))
        stat_rx_frames <= stat_rx_frames + 1'b1;
      if (pkt_tx_val && pkt_tx_eop && (stat_tx_frames != '1))
        stat_tx_frames <= stat_tx_frames + 1'b1;
      if (drop_pulse && (stat_drop_frames != '1))
        stat_drop_frames <= stat_drop_frames + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_xgemac_pkt_loopback.sv
// tb/tb_xgemac_pkt_loopback.sv - directed self-checking bench for xgemac_pkt_loopback
`timescale 1ns/1ps
module tb_xgemac_pkt_loopback;
  localparam int DW = 64;
  localparam int MW = 3;
  typedef logic [DW+MW+1:0] wrd_t;
  typedef logic [DW+MW+2:0] mac_t;

  logic clk = 1'b0;
  always #3.2 clk = ~clk;

  logic rst_n = 1'b0, lb_en = 1'b1, sel = 1'b0;
  logic rx_avail = 1'b0, rx_val = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0, rx_err = 1'b0;
  logic [MW-1:0] rx_mod = '0;
  logic [DW-1:0] rx_data = '0;
  logic tx_full = 1'b0, full_en = 1'b0;

  logic ren_a, tval_a, tsop_a, teop_a, drop_a, ren_b, tval_b, tsop_b, teop_b, drop_b;
  logic [MW-1:0] tmod_a, tmod_b;
  logic [DW-1:0] tdata_a, tdata_b;
  logic [4:0] lvl_a;
  logic [8:0] lvl_b;
`ifdef XGEMAC_LB_STATS_EN
  logic [31:0] sa_rx, sa_tx, sa_dr, sb_rx, sb_tx, sb_dr;
`endif

  xgemac_pkt_loopback #(.DATA_W(DW), .MOD_W(MW), .DEPTH(16), .DROP_ERR(1)) dut_a (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .lb_en(lb_en),
    .pkt_rx_avail(rx_avail & ~sel), .pkt_rx_ren(ren_a), .pkt_rx_val(rx_val & ~sel),
    .pkt_rx_sop(rx_sop), .pkt_rx_eop(rx_eop), .pkt_rx_mod(rx_mod), .pkt_rx_err(rx_err),
    .pkt_rx_data(rx_data), .pkt_tx_full(tx_full), .pkt_tx_val(tval_a), .pkt_tx_sop(tsop_a),
    .pkt_tx_eop(teop_a), .pkt_tx_mod(tmod_a), .pkt_tx_data(tdata_a), .fifo_level(lvl_a),
    .drop_pulse(drop_a)
`ifdef XGEMAC_LB_STATS_EN
    , .stat_rx_frames(sa_rx), .stat_tx_frames(sa_tx), .stat_drop_frames(sa_dr)
`endif
  );

  xgemac_pkt_loopback #(.DATA_W(DW), .MOD_W(MW), .DEPTH(256), .DROP_ERR(0)) dut_b (
    .clk_156m25(clk), .reset_156m25_n(rst_n), .lb_en(lb_en),
    .pkt_rx_avail(rx_avail & sel), .pkt_rx_ren(ren_b), .pkt_rx_val(rx_val & sel),
    .pkt_rx_sop(rx_sop), .pkt_rx_eop(rx_eop), .pkt_rx_mod(rx_mod), .pkt_rx_err(rx_err),
    .pkt_rx_data(rx_data), .pkt_tx_full(tx_full), .pkt_tx_val(tval_b), .pkt_tx_sop(tsop_b),
    .pkt_tx_eop(teop_b), .pkt_tx_mod(tmod_b), .pkt_tx_data(tdata_b), .fifo_level(lvl_b),
    .drop_pulse(drop_b)
`ifdef XGEMAC_LB_STATS_EN
    , .stat_rx_frames(sb_rx), .stat_tx_frames(sb_tx), .stat_drop_frames(sb_dr)
`endif
  );

  logic ren, tval, tsop, teop, drop;
  logic [MW-1:0] tmod;
  logic [DW-1:0] tdata;
  int lvl;
  assign ren   = sel ? ren_b : ren_a;
  assign tval  = sel ? tval_b : tval_a;
  assign tsop  = sel ? tsop_b : tsop_a;
  assign teop  = sel ? teop_b : teop_a;
  assign tmod  = sel ? tmod_b : tmod_a;
  assign tdata = sel ? tdata_b : tdata_a;
  assign drop  = sel ? drop_b : drop_a;
  assign lvl   = sel ? int'(lvl_b) : int'(lvl_a);

  int n_checks = 0, n_fail = 0;

  // MAC receive model: one word per ren, delivered the following cycle
  mac_t mq[$];
  mac_t cur;
  logic ren_d = 1'b0;
  always @(negedge clk) ren_d = ren;
  always @(posedge clk) begin
    #1;
    if (ren_d && mq.size() > 0) begin
      cur = mq.pop_front();
      {rx_err, rx_sop, rx_eop, rx_mod, rx_data} = cur;
      rx_val = 1'b1;
    end else begin
      rx_val = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; rx_mod = '0;
    end
    rx_avail = (mq.size() > 0);
  end

  int fcnt = 0;
  always @(posedge clk) begin
    #1;
    if (full_en) begin
      fcnt    = (fcnt + 1) % 5;
      tx_full = (fcnt < 3);
    end else begin
      tx_full = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  wrd_t oq[$];
  int drops, eop_cyc, sop_cyc, full_viol, max_lvl, disc_ren_low;
  logic full_prev = 1'b0, in_disc = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tval) begin
        oq.push_back({tsop, teop, tmod, tdata});
        if (tsop) sop_cyc = cyc;
        if (full_prev) full_viol++;
      end
      full_prev = tx_full;
      if (rx_val && rx_eop) begin
        eop_cyc = cyc;
        in_disc = 1'b0;
      end else if (in_disc && !ren) begin
        disc_ren_low++;
      end
      if (drop) begin
        drops++;
        in_disc = 1'b1;
      end
      if (lvl > max_lvl) max_lvl = lvl;
    end
  end

  function automatic wrd_t mk(input int f, input int i, input int n, input int mod);
    logic [MW-1:0] m;
    m = (i == n - 1) ? MW'(mod) : '0;
    return {(i == 0), (i == n - 1), m, {32'(f), 32'(i)} ^ 64'hA5A5_0000_0000_5A5A};
  endfunction

  task automatic push_frame(input int f, input int n, input int mod, input logic err);
    for (int i = 0; i < n; i++) mq.push_back({(i == n - 1) ? err : 1'b0, mk(f, i, n, mod)});
  endtask

  task automatic clr();
    oq.delete();
    drops = 0; full_viol = 0; max_lvl = 0; disc_ren_low = 0;
    in_disc = 1'b0; sop_cyc = -1; eop_cyc = -1;
  endtask

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    run(3);
    n_checks++;
    if ({tval_a, tsop_a, teop_a, tmod_a, tdata_a, ren_a, drop_a, lvl_a} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs=%h required 0", {tval_a, tsop_a, teop_a, tmod_a, tdata_a, ren_a, drop_a, lvl_a});
    end
    n_checks++;
    if ({tval_b, tsop_b, teop_b, tmod_b, tdata_b, ren_b, drop_b, lvl_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs=%h required 0", {tval_b, tsop_b, teop_b, tmod_b, tdata_b, ren_b, drop_b, lvl_b});
    end
    rst_n = 1'b1;
    run(2);
  endtask

  task automatic test_single();
    clr(); sel = 1'b0;
    push_frame(1, 8, 3, 1'b0);
    run(60);
    n_checks++;
    if (oq.size() != 8) begin n_fail++; $display("FAIL single_count: got %0d required 8", oq.size()); end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      n_checks++;
      if (oq[i] !== mk(1, i, 8, 3)) begin n_fail++; $display("FAIL single_word%0d: got %h required %h", i, oq[i], mk(1, i, 8, 3)); end
    end
    n_checks++;
    if (sop_cyc - eop_cyc != 2) begin n_fail++; $display("FAIL single_latency: got %0d required 2", sop_cyc - eop_cyc); end
    n_checks++;
    if (drops != 0 || lvl != 0) begin n_fail++; $display("FAIL single_idle: drops=%0d level=%0d required 0/0", drops, lvl); end
  endtask

  task automatic test_err_frames();
    clr(); sel = 1'b0;
    push_frame(2, 8, 3, 1'b1);
    run(60);
    n_checks++;
    if (oq.size() != 0) begin n_fail++; $display("FAIL err_drop_tx: got %0d words required 0", oq.size()); end
    n_checks++;
    if (drops != 1) begin n_fail++; $display("FAIL err_drop_pulse: got %0d required 1", drops); end
    n_checks++;
    if (max_lvl != 0) begin n_fail++; $display("FAIL err_drop_level: got %0d required 0", max_lvl); end
    clr(); sel = 1'b1;
    push_frame(3, 8, 3, 1'b1);
    run(60);
    n_checks++;
    if (oq.size() != 8 || drops != 0) begin n_fail++; $display("FAIL err_fwd_count: words=%0d drops=%0d required 8/0", oq.size(), drops); end
    for (int i = 0; i < 8 && i < oq.size(); i++) begin
      n_checks++;
      if (oq[i] !== mk(3, i, 8, 3)) begin n_fail++; $display("FAIL err_fwd_word%0d: got %h required %h", i, oq[i], mk(3, i, 8, 3)); end
    end
    sel = 1'b0;
    run(2);
  endtask

  task automatic test_oversize();
    clr(); sel = 1'b0;
    push_frame(4, 40, 0, 1'b0);
    push_frame(5, 4, 2, 1'b0);
    run(150);
    n_checks++;
    if (drops != 1) begin n_fail++; $display("FAIL oversize_drops: got %0d required 1", drops); end
    n_checks++;
    if (disc_ren_low != 0 || mq.size() != 0) begin n_fail++; $display("FAIL oversize_ren: ren_low=%0d left=%0d required 0/0", disc_ren_low, mq.size()); end
    n_checks++;
    if (oq.size() != 4) begin n_fail++; $display("FAIL oversize_count: got %0d required 4", oq.size()); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      n_checks++;
      if (oq[i] !== mk(5, i, 4, 2)) begin n_fail++; $display("FAIL oversize_word%0d: got %h required %h", i, oq[i], mk(5, i, 4, 2)); end
    end
  endtask

  task automatic test_back_to_back();
    clr(); sel = 1'b0; full_en = 1'b1;
    for (int f = 0; f < 6; f++) push_frame(10 + f, 8, 0, 1'b0);
    run(400);
    full_en = 1'b0;
    run(20);
    n_checks++;
    if (oq.size() != 48) begin n_fail++; $display("FAIL b2b_count: got %0d required 48", oq.size()); end
    for (int k = 0; k < 48 && k < oq.size(); k++) begin
      n_checks++;
      if (oq[k] !== mk(10 + k / 8, k % 8, 8, 0)) begin n_fail++; $display("FAIL b2b_word%0d: got %h required %h", k, oq[k], mk(10 + k / 8, k % 8, 8, 0)); end
    end
    n_checks++;
    if (full_viol != 0) begin n_fail++; $display("FAIL b2b_full: val after full %0d times required 0", full_viol); end
    n_checks++;
    if (max_lvl > 16 || drops != 0) begin n_fail++; $display("FAIL b2b_level: max=%0d drops=%0d required <=16/0", max_lvl, drops); end
  endtask

  task automatic test_mid_sop();
    clr(); sel = 1'b0;
    for (int i = 0; i < 5; i++) mq.push_back({1'b0, mk(20, i, 100, 0)});
    push_frame(21, 6, 5, 1'b0);
    run(80);
    n_checks++;
    if (drops != 1) begin n_fail++; $display("FAIL midsop_drops: got %0d required 1", drops); end
    n_checks++;
    if (oq.size() != 6) begin n_fail++; $display("FAIL midsop_count: got %0d required 6", oq.size()); end
    for (int i = 0; i < 6 && i < oq.size(); i++) begin
      n_checks++;
      if (oq[i] !== mk(21, i, 6, 5)) begin n_fail++; $display("FAIL midsop_word%0d: got %h required %h", i, oq[i], mk(21, i, 6, 5)); end
    end
  endtask

  task automatic test_reset_mid_tx();
    clr(); sel = 1'b0;
    push_frame(30, 10, 1, 1'b0);
    for (int k = 0; k < 100 && oq.size() < 3; k++) @(negedge clk);
    n_checks++;
    if (oq.size() < 3) begin n_fail++; $display("FAIL rst_tx_start: got %0d words required >=3", oq.size()); end
    #1 rst_n = 1'b0;
    mq.delete();
    #1;
    n_checks++;
    if ({tval_a, tsop_a, teop_a, lvl_a, ren_a} !== '0) begin n_fail++; $display("FAIL rst_tx_async: got %h required 0", {tval_a, tsop_a, teop_a, lvl_a, ren_a}); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    push_frame(31, 4, 6, 1'b0);
    run(60);
    n_checks++;
    if (oq.size() != 4 || drops != 0) begin n_fail++; $display("FAIL rst_after_count: words=%0d drops=%0d required 4/0", oq.size(), drops); end
    for (int i = 0; i < 4 && i < oq.size(); i++) begin
      n_checks++;
      if (oq[i] !== mk(31, i, 4, 6)) begin n_fail++; $display("FAIL rst_after_word%0d: got %h required %h", i, oq[i], mk(31, i, 4, 6)); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_err_frames();
    test_oversize();
    test_back_to_back();
    test_mid_sop();
    test_reset_mid_tx();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
